// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell (two half adders + OR) stepped LSB-first.
// Latency: accept edge -> WIDTH RUN cycles -> one DONE cycle; one result per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; start/a/b are ignored while busy or done.

module half_adder_b (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Counter needs at least one bit so WIDTH=1 still has a legal vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             s1_w, c1_w, c2_w, bit_w, carry_w, last_w;
    logic [WIDTH-1:0] rs_shift_w;

    // Shared full-adder cell working on the current LSBs and the stored carry.
    half_adder_b u_ha1 (
        .x_i (ra_q[0]),
        .y_i (rb_q[0]),
        .s_o (s1_w),
        .c_o (c1_w)
    );

    half_adder_b u_ha2 (
        .x_i (s1_w),
        .y_i (c_q),
        .s_o (bit_w),
        .c_o (c2_w)
    );

    assign carry_w = c1_w | c2_w;
    assign last_w  = (cnt_q == CW'(WIDTH - 1));

    // New sum bit enters at the MSB so the first (LSB) bit lands in rs[0] after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_rs_w1
            assign rs_shift_w = bit_w;
        end else begin : g_rs_wn
            assign rs_shift_w = {bit_w, rs_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and datapath control; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rs_d  = rs_shift_w;
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                c_d   = carry_w;
                cnt_d = cnt_q + CW'(1);
                if (last_w) begin
                    cout_d  = carry_w;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = rs_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout;

    logic       start1, a1, b1;
    logic       busy1, done1, sum1, cout1;

    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Steps the 8-bit DUT until done (bounded); hold keeps start high and scrambles a/b each cycle.
    task automatic wait_done(input bit hold, output int lat, output int nbusy,
                             output logic [8:0] res, output bit got, output bit ovl);
        lat = 0; nbusy = 0; res = '0; got = 1'b0; ovl = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy && done) ovl = 1'b1;
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                res = {cout, sum};
                got = 1'b1;
                break;
            end
            if (hold) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        #12;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8: busy/done/sum/cout=%b required 0", {busy, done, sum, cout});
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_w1: busy/done/sum/cout=%b required 0", {busy1, done1, sum1, cout1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_patterns;
        logic [7:0] av[4] = '{8'h00, 8'hFF, 8'h5A, 8'h80};
        logic [7:0] bv[4] = '{8'h00, 8'h01, 8'hA5, 8'h80};
        logic [8:0] ev[4] = '{9'h000, 9'h100, 9'h0FF, 9'h100};
        int lat, nb;
        logic [8:0] res, e;
        bit got, ovl;
        for (int k = 0; k < 4; k++) begin
            a = av[k]; b = bv[k]; start = 1'b1;
            exp_q.push_back(ev[k]);
            wait_done(1'b0, lat, nb, res, got, ovl);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
            checks++;
            if (!got || res !== e) begin
                errors++;
                $display("FAIL add_%0d: done=%0d {cout,sum}=%h required %h", k, got, res, e);
            end
            checks++;
            if (nb != 8 || lat != 9 || ovl) begin
                errors++;
                $display("FAIL timing_%0d: busy_cycles=%0d done_cycle=%0d overlap=%0d required 8/9/0", k, nb, lat, ovl);
            end
            // Result must hold through IDLE while operands wander.
            for (int j = 0; j < 3; j++) begin
                a = 8'($urandom); b = 8'($urandom);
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== e) begin
                    errors++;
                    $display("FAIL idle_hold_%0d: done=%b busy=%b {cout,sum}=%h required 0/0/%h", k, done, busy, {cout, sum}, e);
                end
            end
        end
    endtask

    task automatic test_hold_operands;
        int lat, nb;
        logic [8:0] res, e;
        bit got, ovl;
        a = 8'h3C; b = 8'h4E; start = 1'b1;
        exp_q.push_back(9'h08A);
        wait_done(1'b1, lat, nb, res, got, ovl);
        start = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        checks++;
        if (!got || res !== e || lat != 9) begin
            errors++;
            $display("FAIL hold_operands: done=%0d {cout,sum}=%h cycle=%0d required %h at 9", got, res, lat, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_after: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        int cyc = 0, last_done = -1, results = 0;
        bit prev_done = 1'b0;
        logic [8:0] e;
        a = 8'($urandom); b = 8'($urandom); start = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b});
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (busy && done) begin
                checks++; errors++;
                $display("FAIL b2b_overlap: busy and done both high at cycle %0d", cyc);
            end
            if (done) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
                checks++;
                if ({cout, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result: {cout,sum}=%h required %h", {cout, sum}, e);
                end
                if (prev_done) begin
                    checks++; errors++;
                    $display("FAIL b2b_pulse: done high two cycles in a row at cycle %0d", cyc);
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != 10) begin
                        errors++;
                        $display("FAIL b2b_interval: %0d cycles between results required 10", cyc - last_done);
                    end
                end
                last_done = cyc;
                results++;
            end
            prev_done = done;
            if (i >= 45) start = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            if (!busy && !done && start) exp_q.push_back({1'b0, a} + {1'b0, b});
            if (i >= 45 && !busy && !done && exp_q.size() == 0) break;
        end
        start = 1'b0;
        checks++;
        if (results < 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: results=%0d pending=%0d required >=4 and 0", results, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, nb;
        logic [8:0] res, e;
        bit got, ovl, seen = 1'b0;
        a = 8'hF7; b = 8'h0F; start = 1'b1;
        exp_q.push_back(9'h106);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid: busy/done/sum/cout=%b required 0", {busy, done, sum, cout});
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done: activity seen after reset=1 required 0");
        end
        a = 8'h12; b = 8'h34; start = 1'b1;
        exp_q.push_back(9'h046);
        wait_done(1'b0, lat, nb, res, got, ovl);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        checks++;
        if (!got || res !== e || nb != 8) begin
            errors++;
            $display("FAIL after_reset_add: done=%0d {cout,sum}=%h busy=%0d required %h/8", got, res, nb, e);
        end
        @(negedge clk);
    endtask

    task automatic test_width1;
        logic [1:0] ev[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic [1:0] e;
        for (int k = 0; k < 4; k++) begin
            a1 = k[1]; b1 = k[0]; start1 = 1'b1;
            exp1_q.push_back(ev[k]);
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_busy_%0d: busy=%b done=%b required 1/0", k, busy1, done1);
            end
            @(negedge clk);
            e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 2'bx;
            checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b1 || {cout1, sum1} !== e) begin
                errors++;
                $display("FAIL w1_done_%0d: busy=%b done=%b {cout,sum}=%b required 0/1/%b", k, busy1, done1, {cout1, sum1}, e);
            end
            @(negedge clk);
            checks++;
            if (done1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_pulse_%0d: done=%b required 0", k, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_patterns();
        test_hold_operands();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
